// File: rtl/spi_defines_pkg.sv
// rtl/spi_defines_pkg.sv - shared SPI widths, timeout default and receive FSM states
package spi_defines_pkg;
  localparam int DATA_WIDTH     = 8;
  localparam int TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    PUSH
  } rx_state_e;
endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - parameterizable-width two-flop synchronizer with synchronous clear
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_deserializer.sv
// rtl/spi_deserializer.sv - SPI receive side: sync sclk/mosi, assemble MSB-first words, push to FIFO
module spi_deserializer #(
  parameter int DATAWIDTH       = spi_defines_pkg::DATA_WIDTH,
  parameter int BITCOUNTERWIDTH = $clog2(DATAWIDTH) + 1,
  parameter int TIMEOUT_CYCLES  = spi_defines_pkg::TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 fifo_full,
  output logic                 write_en,
  output logic [DATAWIDTH-1:0] write_data,
  output logic                 busy,
  output logic                 overflow,
  output logic                 frame_err
);

  import spi_defines_pkg::*;

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_e                state;
  logic [BITCOUNTERWIDTH-1:0] bit_cnt;
  logic [IDLE_W-1:0]        idle_cnt;
  logic [DATAWIDTH-1:0]     shift_reg;
  logic [DATAWIDTH-1:0]     data_r;
  logic [1:0]               sync_q;
  logic                     sclk_s;
  logic                     mosi_s;
  logic                     sclk_d;
  logic                     rise;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({sclk, mosi}),
    .q   (sync_q)
  );

  assign sclk_s = sync_q[1];
  assign mosi_s = sync_q[0];
  assign rise   = sclk_s & ~sclk_d;

  // The strobe is decoded from the PUSH state so the word lands one cycle after its last edge.
  assign write_en   = (state == PUSH) && !fifo_full;
  assign write_data = write_en ? shift_reg : data_r;
  assign busy       = (state == RECV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      shift_reg <= '0;
      data_r    <= '0;
      sclk_d    <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sclk_d    <= sclk_s;
      frame_err <= 1'b0;
      if (rise) begin
        shift_reg <= {shift_reg[DATAWIDTH-2:0], mosi_s};
      end
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (rise) begin
            bit_cnt <= BITCOUNTERWIDTH'(1);
            state   <= RECV;
          end
        end
        RECV: begin
          if (rise) begin
            idle_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == BITCOUNTERWIDTH'(DATAWIDTH - 1)) begin
              state <= PUSH;
            end
          end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            // Upstream stalled mid-word: drop the fragment and flag it.
            state     <= IDLE;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            frame_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        PUSH: begin
          idle_cnt <= '0;
          if (!fifo_full) begin
            data_r <= shift_reg;
          end else begin
            overflow <= 1'b1;
          end
          if (rise) begin
            bit_cnt <= BITCOUNTERWIDTH'(1);
            state   <= RECV;
          end else begin
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_deserializer.sv
// tb/tb_spi_deserializer.sv - randomized self-checking bench for spi_deserializer
module tb_spi_deserializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         mosi;
  logic         fifo_full;
  logic         write_en;
  logic [W-1:0] write_data;
  logic         busy;
  logic         overflow;
  logic         frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int ferr_cnt = 0;
  logic [W-1:0] got_q[$];
  int           got_cyc_q[$];

  spi_deserializer dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .mosi       (mosi),
    .fifo_full  (fifo_full),
    .write_en   (write_en),
    .write_data (write_data),
    .busy       (busy),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (write_en === 1'b1) begin
        got_q.push_back(write_data);
        got_cyc_q.push_back(cyc);
      end
      if (frame_err === 1'b1) ferr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_cyc_q.delete();
    ferr_cnt = 0;
  endtask

  // Serializer model: mosi changes while sclk is low, MSB first.
  task automatic send_bits(input logic [W-1:0] word, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      mosi = word[W-1-i];
      tick(half);
      sclk = 1'b1;
      last_rise_cyc = cyc;
      tick(half);
      sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; fifo_full = 1'b0;
    tick(3);
    checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL reset_write_en got=%b exp=0", write_en); end
    checks++; if (write_data !== '0) begin failures++; $display("FAIL reset_write_data got=%h exp=00", write_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_loopback();
    logic [W-1:0] exp[$];
    exp = '{8'hA5, 8'h3C, 8'hFF};
    clear_obs();
    foreach (exp[i]) begin send_bits(exp[i], W, 2); tick(3); end
    tick(6);
    checks++; if (got_q.size() != exp.size()) begin failures++; $display("FAIL loopback_count got=%0d exp=%0d", got_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp[i]) begin failures++; $display("FAIL loopback_word%0d got=%h exp=%h", i, got_q[i], exp[i]); end
    end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL loopback_overflow got=%b exp=0", overflow); end
    checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL loopback_frame_err got=%0d exp=0", ferr_cnt); end
    checks++; if (write_en !== 1'b0 || write_data !== 8'hFF) begin failures++; $display("FAIL loopback_hold got=%b/%h exp=0/ff", write_en, write_data); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_bits(8'h01, W, 1);
    send_bits(8'h80, W, 1);
    tick(8);
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0] !== 8'h01) begin failures++; $display("FAIL b2b_word0 got=%h exp=01", got_q[0]); end
      checks++; if (got_q[1] !== 8'h80) begin failures++; $display("FAIL b2b_word1 got=%h exp=80", got_q[1]); end
    end
  endtask

  task automatic test_latency();
    logic [W-1:0] w;
    w = W'($urandom);
    clear_obs();
    send_bits(w, W, 3);
    tick(8);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL latency_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== w) begin failures++; $display("FAIL latency_word got=%h exp=%h", got_q[0], w); end
      // 2 synchronizer stages to detect the edge, then one cycle to the strobe.
      checks++; if (got_cyc_q[0] != last_rise_cyc + 3) begin failures++; $display("FAIL latency_cycle got=%0d exp=%0d", got_cyc_q[0], last_rise_cyc + 3); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp[$];
    logic [W-1:0] w;
    clear_obs();
    for (int n = 0; n < 12; n++) begin
      w = W'($urandom);
      exp.push_back(w);
      send_bits(w, W, $urandom_range(1, 4));
      tick($urandom_range(0, 20));
    end
    tick(8);
    checks++; if (got_q.size() != exp.size()) begin failures++; $display("FAIL random_count got=%0d exp=%0d", got_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp[i]) begin failures++; $display("FAIL random_word%0d got=%h exp=%h", i, got_q[i], exp[i]); end
    end
    checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL random_frame_err got=%0d exp=0", ferr_cnt); end
  endtask

  task automatic test_timeout();
    clear_obs();
    send_bits(8'hE0, 3, 2);
    tick(40);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL timeout_busy_early got=%b exp=1", busy); end
    checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL timeout_early_err got=%0d exp=0", ferr_cnt); end
    tick(40);
    checks++; if (ferr_cnt != 1) begin failures++; $display("FAIL timeout_err_pulses got=%0d exp=1", ferr_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b exp=0", busy); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL timeout_no_write got=%0d exp=0", got_q.size()); end
    clear_obs();
    send_bits(8'hC3, W, 2);
    tick(8);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL timeout_next_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'hC3) begin failures++; $display("FAIL timeout_next_word got=%h exp=c3", got_q[0]); end
    end
  endtask

  task automatic test_full();
    clear_obs();
    fifo_full = 1'b1;
    send_bits(8'h5A, W, 2);
    tick(8);
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL full_no_write got=%0d exp=0", got_q.size()); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_overflow got=%b exp=1", overflow); end
    fifo_full = 1'b0;
    tick(2);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_overflow_sticky got=%b exp=1", overflow); end
    send_bits(8'h11, W, 2);
    tick(8);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL full_next_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'h11) begin failures++; $display("FAIL full_next_word got=%h exp=11", got_q[0]); end
    end
  endtask

  task automatic test_midreset();
    clear_obs();
    send_bits(8'hF0, 5, 2);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow got=%b exp=0", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    send_bits(8'h0F, W, 2);
    tick(8);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL midrst_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== 8'h0F) begin failures++; $display("FAIL midrst_word got=%h exp=0f", got_q[0]); end
    end
    checks++; if (ferr_cnt != 0) begin failures++; $display("FAIL midrst_frame_err got=%0d exp=0", ferr_cnt); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_latency();
    test_random();
    test_timeout();
    test_full();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_deserializer.md
SPI_DESERIALIZER -- requirements
Module: spi_deserializer

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default DATA_WIDTH from spi_defines_pkg (8), meaning receive word width in bits.
REQ-002 The block SHALL have parameter BITCOUNTERWIDTH, default $clog2(DATAWIDTH)+1, meaning the bit-counter width, which holds 0..DATAWIDTH.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the clk cycles without an sclk rising edge before a partial word is abandoned.
REQ-004 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port sclk, input, 1, the serial clock from the upstream spi_serializer, asynchronous to clk.
REQ-007 The block SHALL have port mosi, input, 1, serial data, MSB first, valid at the sclk rising edge.
REQ-008 The block SHALL have port fifo_full, input, 1, the full flag of the downstream receive FIFO.
REQ-009 The block SHALL have port write_en, output, 1, a one-cycle FIFO write strobe.
REQ-010 The block SHALL have port write_data, output, DATAWIDTH, the assembled word, valid while write_en=1.
REQ-011 The block SHALL have port busy, output, 1, high while a word is partially received.
REQ-012 The block SHALL have port overflow, output, 1, sticky: a completed word was dropped because fifo_full=1.
REQ-013 The block SHALL have port frame_err, output, 1, a one-cycle pulse raised when a partial word is abandoned on timeout.

Function
REQ-014 The block SHALL pass sclk and mosi through two-flop synchronizers; edge detection SHALL use the synchronized sclk and its one-cycle-delayed copy.
REQ-015 On a synchronized sclk rising edge, the block SHALL shift the synchronized mosi into the shift register LSB (shift left), so the first bit lands in the MSB of the word.
REQ-016 FSM states SHALL be IDLE, RECV and PUSH.
REQ-017 IDLE -> RECV on a rising edge; that edge's bit SHALL be captured and bit_cnt set to 1.
REQ-018 In RECV, each rising edge SHALL increment bit_cnt; when bit_cnt reaches DATAWIDTH, the FSM SHALL go to PUSH on the next cycle.
REQ-019 In PUSH, if fifo_full=0, write_en=1 and write_data=shift register for exactly one cycle; if fifo_full=1, write_en SHALL stay 0, the word is dropped and overflow is set; next state is IDLE.
REQ-020 Write latency SHALL be exactly 1 clk cycle from the cycle the last-bit edge is detected to write_en high.
REQ-021 A rising edge detected while in PUSH SHALL start the next word: the bit is captured, bit_cnt=1 and the next state is RECV, so no bit is lost on back-to-back words.
REQ-022 The idle counter SHALL clear on every rising edge and increment in RECV otherwise; at TIMEOUT_CYCLES it SHALL force RECV -> IDLE, pulse frame_err for 1 cycle, clear bit_cnt and write nothing.
REQ-023 busy SHALL be 1 in RECV and 0 in IDLE and PUSH.
REQ-024 overflow SHALL clear only on rst; fifo_full SHALL be sampled only in PUSH.
REQ-025 write_data SHALL hold its last value when write_en=0.

Reset
REQ-026 On rst=1 at a clk edge, the block SHALL go to IDLE and clear bit_cnt, the idle counter, the shift register, the synchronizers (to 0), write_en, write_data, busy, overflow and frame_err to 0.
REQ-027 Reset mid-word SHALL discard the partial word without asserting frame_err or write_en; reception SHALL restart at the first rising edge after rst deasserts.

Structure
REQ-028 The FSM state enum (IDLE, RECV, PUSH) and the default TIMEOUT_CYCLES SHALL live in spi_defines_pkg beside DATA_WIDTH.
REQ-029 The block SHALL use one sub-module, sync_2ff (a parameterizable-width two-flop synchronizer), instantiated once for {sclk, mosi}.
REQ-030 The block SHALL use no FIFO storage internally; buffering belongs to the downstream FIFO.

Verification
REQ-031 Loopback: spi_serializer feeding spi_deserializer with 0xA5, 0x3C and 0xFF SHALL produce three write_en pulses carrying 0xA5, 0x3C and 0xFF in order, with overflow=0 and frame_err=0.
REQ-032 Back-to-back: words 0x01 and 0x80 sent with no gap between sclk edges SHALL produce two writes, 0x01 then 0x80, with no lost bit.
REQ-033 Full: fifo_full=1 held while 0x5A completes SHALL give no write_en and overflow=1; overflow SHALL stay 1 after fifo_full drops and the next word 0x11 SHALL still be written.
REQ-034 Timeout: 3 bits sent, then sclk held for 64+ cycles, SHALL give one frame_err pulse, busy back to 0 and no write; a following full word 0xC3 SHALL be written correctly.
REQ-035 Mid-word reset: rst pulsed after 5 bits of 0xF0 SHALL give no write; a following word 0x0F SHALL be written as 0x0F.
REQ-036 Latency check: write_en SHALL rise exactly 1 clk after the cycle the 8th synchronized rising edge is detected.
